// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until operands arrive on the CDB,
// then dispatches the lowest-index ready entry to the ALU, one per cycle.
module alu_rs #(
  parameter int RS_SIZE = 4,
  parameter int ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             iss_valid,
  input  logic [3:0]       iss_op,
  input  logic             iss_qj_busy,
  input  logic             iss_qk_busy,
  input  logic [31:0]      iss_vj,
  input  logic [31:0]      iss_vk,
  input  logic [ROB_W-1:0] iss_qj,
  input  logic [ROB_W-1:0] iss_qk,
  input  logic [ROB_W-1:0] iss_rob,
  output logic             full_out,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob,
  input  logic [31:0]      cdb_val,
  output logic             alu_valid,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [ROB_W-1:0] alu_rob
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic             busy;
    logic [3:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qj_busy;
    logic             qk_busy;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] rob;
  } ent_t;

  ent_t ent_q [RS_SIZE];
  ent_t ent_d [RS_SIZE];

  logic             alu_valid_q, alu_valid_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [ROB_W-1:0] alu_rob_q, alu_rob_d;

  logic             full;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             disp_found;
  logic [IDX_W-1:0] disp_idx;
  ent_t             new_ent;

  always_comb begin
    full       = 1'b1;
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!ent_q[i].busy) full = 1'b0;
      if (!ent_q[i].busy && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      // readiness is judged on pre-edge state only
      if (ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy
          && !disp_found) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.op      = iss_op;
    new_ent.vj      = iss_vj;
    new_ent.vk      = iss_vk;
    new_ent.qj_busy = iss_qj_busy;
    new_ent.qk_busy = iss_qk_busy;
    new_ent.qj      = iss_qj;
    new_ent.qk      = iss_qk;
    new_ent.rob     = iss_rob;
    if (cdb_valid && iss_qj_busy && iss_qj == cdb_rob) begin
      new_ent.qj_busy = 1'b0;
      new_ent.vj      = cdb_val;
    end
    if (cdb_valid && iss_qk_busy && iss_qk == cdb_rob) begin
      new_ent.qk_busy = 1'b0;
      new_ent.vk      = cdb_val;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_valid) begin
        if (ent_q[i].qj_busy && ent_q[i].qj == cdb_rob) begin
          ent_d[i].qj_busy = 1'b0;
          ent_d[i].vj      = cdb_val;
        end
        if (ent_q[i].qk_busy && ent_q[i].qk == cdb_rob) begin
          ent_d[i].qk_busy = 1'b0;
          ent_d[i].vk      = cdb_val;
        end
      end
    end
    alu_valid_d = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_rob_d   = alu_rob_q;
    if (disp_found) begin
      alu_valid_d             = 1'b1;
      alu_op_d                = ent_q[disp_idx].op;
      alu_a_d                 = ent_q[disp_idx].vj;
      alu_b_d                 = ent_q[disp_idx].vk;
      alu_rob_d               = ent_q[disp_idx].rob;
      ent_d[disp_idx].busy    = 1'b0;
    end
    if (iss_valid && !full) ent_d[free_idx] = new_ent;
    if (clear_in) begin
      alu_valid_d = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_rob_q   <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  assign full_out  = full;
  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_rob   = alu_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue, wakeup, bypass, full,
// freeze, flush and async reset.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        iss_valid;
  logic [3:0]  iss_op;
  logic        iss_qj_busy;
  logic        iss_qk_busy;
  logic [31:0] iss_vj;
  logic [31:0] iss_vk;
  logic [3:0]  iss_qj;
  logic [3:0]  iss_qk;
  logic [3:0]  iss_rob;
  logic        full_out;
  logic        cdb_valid;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_val;
  logic        alu_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_rob;

  int n_cmp = 0;
  int n_bad = 0;

  alu_rs #(.RS_SIZE(4), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_in(clear_in), .iss_valid(iss_valid), .iss_op(iss_op),
    .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj),
    .iss_qk(iss_qk), .iss_rob(iss_rob), .full_out(full_out),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_rob(alu_rob)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clear_in    = 1'b0;
    iss_valid   = 1'b0;
    iss_op      = '0;
    iss_qj_busy = 1'b0;
    iss_qk_busy = 1'b0;
    iss_vj      = '0;
    iss_vk      = '0;
    iss_qj      = '0;
    iss_qk      = '0;
    iss_rob     = '0;
    cdb_valid   = 1'b0;
    cdb_rob     = '0;
    cdb_val     = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic qjb,
                       input logic [3:0] qj, input logic [31:0] vj,
                       input logic qkb, input logic [3:0] qk,
                       input logic [31:0] vk, input logic [3:0] rob);
    iss_valid   = 1'b1;
    iss_op      = op;
    iss_qj_busy = qjb;
    iss_qj      = qj;
    iss_vj      = vj;
    iss_qk_busy = qkb;
    iss_qk      = qk;
    iss_vk      = vk;
    iss_rob     = rob;
  endtask

  task automatic cdb(input logic [3:0] rob, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_rob   = rob;
    cdb_val   = val;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    idle();
    rdy_in = 1'b1;
    rst_in = 1'b0;
    #2;
    chk("rst_valid", 32'(alu_valid), 32'd0);
    chk("rst_full", 32'(full_out), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    step();
    step();
    #2 rst_in = 1'b1;
    step();

    // single ready op
    issue(4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd2);
    step();
    idle();
    chk("iss_valid0", 32'(alu_valid), 32'd0);
    step();
    chk("d_valid", 32'(alu_valid), 32'd1);
    chk("d_op", 32'(alu_op), 32'd3);
    chk("d_a", alu_a, 32'd5);
    chk("d_b", alu_b, 32'd7);
    chk("d_rob", 32'(alu_rob), 32'd2);
    step();
    chk("d_valid_off", 32'(alu_valid), 32'd0);
    chk("d_a_hold", alu_a, 32'd5);

    // wait on tag 6, wrong tag first
    issue(4'd1, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1, 4'd3);
    step();
    idle();
    cdb(4'd5, 32'hDEAD);
    step();
    idle();
    chk("wrong_tag", 32'(alu_valid), 32'd0);
    step();
    cdb(4'd6, 32'h10);
    step();
    idle();
    chk("wake_lat", 32'(alu_valid), 32'd0);
    step();
    chk("wake_valid", 32'(alu_valid), 32'd1);
    chk("wake_a", alu_a, 32'h10);
    chk("wake_b", alu_b, 32'd1);
    chk("wake_rob", 32'(alu_rob), 32'd3);

    // issue-time bypass
    issue(4'd2, 1'b0, 4'd0, 32'd2, 1'b1, 4'd9, 32'd0, 4'd4);
    cdb(4'd9, 32'hAB);
    step();
    idle();
    step();
    chk("byp_valid", 32'(alu_valid), 32'd1);
    chk("byp_b", alu_b, 32'hAB);
    chk("byp_a", alu_a, 32'd2);

    // issue and dispatch in the same edge
    issue(4'd4, 1'b0, 4'd0, 32'd11, 1'b0, 4'd0, 32'd0, 4'd5);
    step();
    issue(4'd4, 1'b0, 4'd0, 32'd22, 1'b0, 4'd0, 32'd0, 4'd6);
    step();
    idle();
    chk("same_rob_a", 32'(alu_rob), 32'd5);
    step();
    chk("same_valid_b", 32'(alu_valid), 32'd1);
    chk("same_rob_b", 32'(alu_rob), 32'd6);
    step();

    // fill all four entries on tag 1
    for (int i = 0; i < 4; i++) begin
      issue(4'd7, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(i), 4'(8 + i));
      step();
      if (i == 2) chk("full_at3", 32'(full_out), 32'd0);
    end
    idle();
    chk("full_at4", 32'(full_out), 32'd1);
    issue(4'd7, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd15);
    step();
    idle();
    chk("full_hold", 32'(full_out), 32'd1);
    step();
    chk("ignored", 32'(alu_valid), 32'd0);
    cdb(4'd1, 32'h55);
    step();
    idle();
    chk("fill_wake", 32'(alu_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_valid", 32'(alu_valid), 32'd1);
      chk("fill_rob", 32'(alu_rob), 32'(8 + i));
      chk("fill_b", alu_b, 32'(i));
      chk("fill_a", alu_a, 32'h55);
      if (i == 0) chk("fill_full0", 32'(full_out), 32'd0);
    end
    step();
    chk("fill_done", 32'(alu_valid), 32'd0);

    // freeze then flush
    issue(4'd1, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1);
    step();
    issue(4'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'd0, 4'd2);
    step();
    issue(4'd1, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0, 4'd5);
    step();
    idle();
    step();
    chk("pre_frz_rob", 32'(alu_rob), 32'd5);
    rdy_in = 1'b0;
    cdb(4'd3, 32'h99);
    issue(4'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_valid", 32'(alu_valid), 32'd1);
      chk("frz_rob", 32'(alu_rob), 32'd5);
      chk("frz_a", alu_a, 32'h77);
    end
    rdy_in = 1'b1;
    idle();
    step();
    chk("frz_nowake", 32'(alu_valid), 32'd0);
    chk("frz_full", 32'(full_out), 32'd0);
    clear_in = 1'b1;
    issue(4'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd6);
    step();
    idle();
    chk("clr_valid", 32'(alu_valid), 32'd0);
    chk("clr_full", 32'(full_out), 32'd0);
    step();
    chk("clr_drop", 32'(alu_valid), 32'd0);
    cdb(4'd3, 32'h1);
    step();
    idle();
    step();
    chk("clr_empty", 32'(alu_valid), 32'd0);

    // async reset mid-dispatch
    issue(4'd5, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd4, 4'd7);
    step();
    idle();
    step();
    chk("pre_rst_v", 32'(alu_valid), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_valid", 32'(alu_valid), 32'd0);
    chk("arst_op", 32'(alu_op), 32'd0);
    chk("arst_a", alu_a, 32'd0);
    chk("arst_b", alu_b, 32'd0);
    chk("arst_rob", 32'(alu_rob), 32'd0);
    step();
    #2 rst_in = 1'b1;
    step();
    chk("post_full", 32'(full_out), 32'd0);
    issue(4'd6, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd8, 4'd3);
    step();
    idle();
    step();
    chk("post_valid", 32'(alu_valid), 32'd1);
    chk("post_rob", 32'(alu_rob), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
